// File: rtl/sigma_mem_pkg.sv
// Shared widths, state encoding, request payload and byte-lane ranges for the Sigma memory responder.
// Sigma bit numbering: bit 0 is the MSB, byte lane 0 is bits 0:7.
package sigma_mem_pkg;

    localparam int unsigned ADDR_W     = 17;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    localparam int unsigned LANE0_FIRST = 0;
    localparam int unsigned LANE0_LAST  = 7;
    localparam int unsigned LANE1_FIRST = 8;
    localparam int unsigned LANE1_LAST  = 15;
    localparam int unsigned LANE2_FIRST = 16;
    localparam int unsigned LANE2_LAST  = 23;
    localparam int unsigned LANE3_FIRST = 24;
    localparam int unsigned LANE3_LAST  = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Request fields captured when a transaction is accepted.
    typedef struct packed {
        logic                  we;
        logic [0:ADDR_W-1]     addr;
        logic [0:WORD_W-1]     wdata;
        logic [0:NUM_LANES-1]  byte_en;
    } mem_req_t;

    // Unsigned compare against the implemented size; nothing above it aliases.
    function automatic logic addr_in_range(input logic [0:ADDR_W-1] addr,
                                           input int unsigned       depth_log2);
        logic [ADDR_W:0] limit;
        limit = (ADDR_W + 1)'(1) << depth_log2;
        return ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/sigma_mem_array.sv
// Single-port synchronous word RAM with big-endian byte-lane write enables and registered read.
module sigma_mem_array
    import sigma_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [0:WORD_W-1]     wdata,
    input  logic [0:NUM_LANES-1]  byte_en,
    output logic [0:WORD_W-1]     rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [0:WORD_W-1] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                if (byte_en[0]) mem[index][LANE0_FIRST:LANE0_LAST] <= wdata[LANE0_FIRST:LANE0_LAST];
                if (byte_en[1]) mem[index][LANE1_FIRST:LANE1_LAST] <= wdata[LANE1_FIRST:LANE1_LAST];
                if (byte_en[2]) mem[index][LANE2_FIRST:LANE2_LAST] <= wdata[LANE2_FIRST:LANE2_LAST];
                if (byte_en[3]) mem[index][LANE3_FIRST:LANE3_LAST] <= wdata[LANE3_FIRST:LANE3_LAST];
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/sigma_memory_responder.sv
// Word-addressed main-memory responder for the Sigma CPU: req/ack handshake, wait states, NXM flag.
// Optional SIGMA_MEM_STATS_EN adds rd_count, wr_count and nxm_count statistics outputs.
module sigma_memory_responder
    import sigma_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [15:31] addr,
    input  logic [0:31]  wdata,
    input  logic [0:3]   byte_en,
    output logic [0:31]  rdata,
    output logic         ack,
    output logic         nxm,
`ifdef SIGMA_MEM_STATS_EN
    output logic [0:15]  rd_count,
    output logic [0:15]  wr_count,
    output logic [0:7]   nxm_count,
`endif
    output logic         busy
);

    state_t                state;
    state_t                next_state;
    mem_req_t              req_in;
    mem_req_t              lat_req;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;
    logic                  lat_load;
    logic                  in_range;
    logic                  array_en;
    logic [DEPTH_LOG2-1:0] array_index;
    logic [0:WORD_W-1]     array_q;
    logic [0:WORD_W-1]     rdata_d;
    logic                  ack_d;
    logic                  nxm_d;
    logic                  busy_d;

    assign req_in      = '{we: we, addr: addr, wdata: wdata, byte_en: byte_en};
    assign in_range    = addr_in_range(lat_req.addr, DEPTH_LOG2);
    assign array_index = lat_req.addr[ADDR_W-DEPTH_LOG2 +: DEPTH_LOG2];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    next_state = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_CNT_W'(1)) begin
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath control; ack and read data land together on the RESP edge.
    always_comb begin
        lat_load   = 1'b0;
        wait_cnt_d = wait_cnt;
        array_en   = 1'b0;
        ack_d      = 1'b0;
        nxm_d      = nxm;
        rdata_d    = rdata;
        busy_d     = (next_state != IDLE);
        unique case (state)
            IDLE: begin
                if (req) begin
                    lat_load   = 1'b1;
                    wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
                    nxm_d      = 1'b0;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt - WAIT_CNT_W'(1);
            end
            ACCESS: begin
                array_en = in_range;
                nxm_d    = ~in_range;
            end
            RESP: begin
                ack_d = 1'b1;
                if (!lat_req.we) begin
                    rdata_d = nxm ? '0 : array_q;
                end
            end
            default: begin
                wait_cnt_d = '0;
            end
        endcase
    end

    // Registered outputs and latched request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            lat_req  <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
            nxm      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_d;
            if (lat_load) begin
                lat_req <= req_in;
            end
            rdata <= rdata_d;
            ack   <= ack_d;
            nxm   <= nxm_d;
            busy  <= busy_d;
        end
    end

    sigma_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock   (clock),
        .en      (array_en),
        .we      (lat_req.we),
        .index   (array_index),
        .wdata   (lat_req.wdata),
        .byte_en (lat_req.byte_en),
        .rdata   (array_q)
    );

`ifdef SIGMA_MEM_STATS_EN
    // Completed-transaction statistics; the NXM count saturates, the others wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count  <= '0;
            wr_count  <= '0;
            nxm_count <= '0;
        end else if (state == RESP) begin
            if (nxm) begin
                if (nxm_count != 8'hFF) begin
                    nxm_count <= nxm_count + 8'd1;
                end
            end else if (lat_req.we) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sigma_memory_responder.sv
// Randomized self-checking bench for sigma_memory_responder against a word-level reference memory.
module tb_sigma_memory_responder;

    localparam int unsigned DEPTH_LOG2  = 12;
    localparam int unsigned WAIT_STATES = 2;
    localparam int unsigned LAT         = WAIT_STATES + 3;
    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
    localparam int          MAX_CYC     = 40;

    logic         clock = 1'b0;
    logic         reset;
    logic         req;
    logic         we;
    logic [15:31] addr;
    logic [0:31]  wdata;
    logic [0:3]   byte_en;
    logic [0:31]  rdata;
    logic         ack;
    logic         nxm;
    logic         busy;
`ifdef SIGMA_MEM_STATS_EN
    logic [0:15]  rd_count;
    logic [0:15]  wr_count;
    logic [0:7]   nxm_count;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [int];
    logic [31:0] last_rdata;
    int          m_rd;
    int          m_wr;
    int          m_nxm;

    always #5 clock = ~clock;

    sigma_memory_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .byte_en   (byte_en),
        .rdata     (rdata),
        .ack       (ack),
        .nxm       (nxm),
`ifdef SIGMA_MEM_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .nxm_count (nxm_count),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference write: be bit j enables the j-th byte counted from the least significant end.
    task automatic model_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        logic [31:0] old;
        mask = '0;
        for (int j = 0; j < 4; j++) begin
            if (be[j]) mask = mask | (32'hFF << (8 * j));
        end
        old = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
        model[int'(a)] = (old & ~mask) | (d & mask);
    endtask

    // One isolated transaction; request fields are scrambled right after acceptance.
    task automatic run_txn(input bit w, input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
        int          cyc;
        bit          exp_nxm;
        logic [31:0] exp;
        exp_nxm = (a >= 17'(DEPTH));
        req = 1'b1; we = w; addr = a; wdata = d; byte_en = be;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) begin
                chk("nxm_clr", 32'(nxm), 32'h0);
                req = 1'b0; we = 1'($urandom); addr = 17'($urandom);
                wdata = $urandom; byte_en = 4'($urandom);
            end
        end while (!ack && cyc < MAX_CYC);
        chk("latency", 32'(cyc), 32'(LAT));
        chk("nxm", 32'(nxm), 32'(exp_nxm));
        if (!w) begin
            exp = exp_nxm ? 32'h0 : model[int'(a)];
            last_rdata = exp;
            if (!exp_nxm) m_rd++;
            chk("rdata", rdata, last_rdata);
        end else begin
            if (!exp_nxm) begin
                model_write(a, d, be);
                m_wr++;
            end
            chk("rdata_hold", rdata, last_rdata);
        end
        if (exp_nxm && m_nxm < 255) m_nxm++;
        @(posedge clock); #1;
        chk("ack_pulse", 32'(ack), 32'h0);
        chk("busy_idle", 32'(busy), 32'h0);
    endtask

    function automatic logic [16:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4) return 17'($urandom_range(0, 63));
        if (r < 8) return 17'($urandom_range(DEPTH - 32, DEPTH - 1));
        return 17'($urandom_range(DEPTH, 32'h1FFFF));
    endfunction

    initial begin
        int          cyc;
        logic [31:0] old20;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; byte_en = '0;
        m_rd = 0; m_wr = 0; m_nxm = 0; last_rdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_nxm", 32'(nxm), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_busy", 32'(busy), 32'h0);

        // Fill the working set with known contents.
        run_txn(1'b1, 17'h0, 32'h0123_4567, 4'hF);
        for (int i = 1; i < 64; i++) run_txn(1'b1, 17'(i), $urandom, 4'hF);
        for (int i = DEPTH - 32; i < DEPTH; i++) run_txn(1'b1, 17'(i), $urandom, 4'hF);

        run_txn(1'b0, 17'h0, 32'h0, 4'h0);
        chk("word0", rdata, 32'h0123_4567);

        // Byte-lane merge.
        run_txn(1'b1, 17'h00010, 32'hDEAD_BEEF, 4'b1111);
        run_txn(1'b1, 17'h00010, 32'h0000_00AA, 4'b0001);
        run_txn(1'b0, 17'h00010, 32'h0, 4'h0);
        chk("lane_merge", rdata, 32'hDEAD_BEAA);
        run_txn(1'b1, 17'h00011, 32'hFFFF_FFFF, 4'b0000);
        run_txn(1'b0, 17'h00011, 32'h0, 4'h0);

        // First address beyond the implemented size, and the top of the address space.
        run_txn(1'b0, 17'h01000, 32'h0, 4'h0);
        chk("nxm_rd_zero", rdata, 32'h0);
        run_txn(1'b1, 17'h01000, 32'h5555_AAAA, 4'hF);
        run_txn(1'b1, 17'h1FFFF, 32'h1234_5678, 4'hF);
        run_txn(1'b0, 17'h0, 32'h0, 4'h0);
        run_txn(1'b0, 17'(DEPTH - 1), 32'h0, 4'h0);

        // Back-to-back reads with req held high.
        req = 1'b1; we = 1'b0; addr = 17'h00001; byte_en = 4'h0;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                @(posedge clock); #1;
                cyc++;
                if (cyc == 1 && i > 0) chk("b2b_busy_hi", 32'(busy), 32'h1);
            end while (!ack && cyc < MAX_CYC);
            chk("b2b_spacing", 32'(cyc), 32'(LAT));
            chk("b2b_busy_lo", 32'(busy), 32'h0);
            last_rdata = model[i + 1];
            m_rd++;
            chk("b2b_rdata", rdata, last_rdata);
            if (i < 2) addr = 17'(i + 2);
            else req = 1'b0;
        end
        @(posedge clock); #1;
        chk("b2b_end_ack", 32'(ack), 32'h0);

        // Reset while the write to 0x20 is still waiting.
        old20 = model[32];
        req = 1'b1; we = 1'b1; addr = 17'h00020; wdata = ~old20; byte_en = 4'hF;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("abort_ack", 32'(ack), 32'h0);
        end
        reset = 1'b0;
        m_rd = 0; m_wr = 0; m_nxm = 0; last_rdata = '0;
        chk("abort_rdata", rdata, 32'h0);
        @(posedge clock); #1;
        chk("abort_ack_after", 32'(ack), 32'h0);
        run_txn(1'b0, 17'h00020, 32'h0, 4'h0);
        chk("abort_word", rdata, old20);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom), pick_addr(), $urandom, 4'($urandom));
        end

`ifdef SIGMA_MEM_STATS_EN
        chk("rd_count", 32'(rd_count), 32'(m_rd & 16'hFFFF));
        chk("wr_count", 32'(wr_count), 32'(m_wr & 16'hFFFF));
        chk("nxm_count", 32'(nxm_count), 32'(m_nxm));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
